// File: rtl/clint_bridge.sv
// clint_bridge: CPU data-port front end for the core-local interruptor.
// Accepts one request at a time, validates it against the CLINT window and
// splits it into one or two 32-bit register beats on the CLINT port.
//
// state | meaning
// IDLE  | ready for a new request
// WR_LO | low (or only) write beat on the CLINT port
// WR_HI | high write beat of a dword write
// RD_A  | read address for the low word presented
// RD_B  | low word captured; high address presented for dword reads
// RD_C  | high word captured (dword reads only)
// RESP  | response held until consumed
module clint_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h6000_0000,
  parameter logic [31:0] WIN_SIZE  = 32'h0001_0000
) (
  input  logic        CLK,
  input  logic        RST_X,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic        i_req_we,
  input  logic [1:0]  i_req_size,
  input  logic [63:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [63:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic [15:0] o_offset,
  output logic        o_we,
  output logic [31:0] o_wdata,
  input  logic [31:0] i_rdata
);

  typedef enum logic [2:0] {IDLE, WR_LO, WR_HI, RD_A, RD_B, RD_C, RESP} state_t;

  state_t      state;
  logic [15:0] off_q;
  logic [1:0]  addr_lo_q;
  logic [1:0]  size_q;
  logic [31:0] wdata_hi_q;
  logic [31:0] lo_q;

  logic [31:0] off_c;
  logic        out_win_c;
  logic        misalign_c;
  logic        bad_wr_c;
  logic        err_c;

  // Shift the addressed lane down and zero-extend to the access size.
  function automatic logic [63:0] fmt_rd(input logic [31:0] d, input logic [1:0] sz,
                                         input logic [1:0] a);
    logic [31:0] sh;
    logic [31:0] mask;
    sh   = d >> {a, 3'b000};
    mask = (sz == 2'd0) ? 32'h0000_00FF :
           (sz == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    return {32'h0, sh & mask};
  endfunction

  // Request validation, evaluated on the incoming request at accept time.
  always_comb begin
    off_c      = i_req_addr - BASE_ADDR;
    out_win_c  = (i_req_addr < BASE_ADDR) || (off_c >= WIN_SIZE);
    misalign_c = 1'b0;
    case (i_req_size)
      2'd1:    misalign_c = i_req_addr[0];
      2'd2:    misalign_c = (i_req_addr[1:0] != 2'b00);
      2'd3:    misalign_c = (i_req_addr[2:0] != 3'b000);
      default: misalign_c = 1'b0;
    endcase
    bad_wr_c = i_req_we && (i_req_size < 2'd2);
    err_c    = out_win_c || misalign_c || bad_wr_c;
  end

  // Sequencer with registered bus-side and CLINT-side outputs.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state       <= IDLE;
      o_req_ready <= 1'b1;
      o_rsp_valid <= 1'b0;
      o_rsp_err   <= 1'b0;
      o_rsp_rdata <= 64'h0;
      o_offset    <= 16'h0;
      o_we        <= 1'b0;
      o_wdata     <= 32'h0;
      off_q       <= 16'h0;
      addr_lo_q   <= 2'b00;
      size_q      <= 2'd0;
      wdata_hi_q  <= 32'h0;
      lo_q        <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req_valid && o_req_ready) begin
            o_req_ready <= 1'b0;
            off_q       <= off_c[15:0];
            addr_lo_q   <= i_req_addr[1:0];
            size_q      <= i_req_size;
            wdata_hi_q  <= i_req_wdata[63:32];
            if (err_c) begin
              state       <= RESP;
              o_rsp_valid <= 1'b1;
              o_rsp_err   <= 1'b1;
              o_rsp_rdata <= 64'h0;
            end else if (i_req_we) begin
              state    <= WR_LO;
              o_offset <= {off_c[15:2], 2'b00};
              o_we     <= 1'b1;
              o_wdata  <= i_req_wdata[31:0];
            end else begin
              state    <= RD_A;
              o_offset <= {off_c[15:2], 2'b00};
              o_we     <= 1'b0;
            end
          end
        end
        WR_LO: begin
          if (size_q == 2'd3) begin
            state    <= WR_HI;
            o_offset <= off_q + 16'd4;
            o_we     <= 1'b1;
            o_wdata  <= wdata_hi_q;
          end else begin
            state       <= RESP;
            o_we        <= 1'b0;
            o_rsp_valid <= 1'b1;
            o_rsp_err   <= 1'b0;
            o_rsp_rdata <= 64'h0;
          end
        end
        WR_HI: begin
          state       <= RESP;
          o_we        <= 1'b0;
          o_rsp_valid <= 1'b1;
          o_rsp_err   <= 1'b0;
          o_rsp_rdata <= 64'h0;
        end
        RD_A: begin
          state <= RD_B;
          if (size_q == 2'd3) o_offset <= off_q + 16'd4;
        end
        RD_B: begin
          lo_q <= i_rdata;
          if (size_q == 2'd3) begin
            state <= RD_C;
          end else begin
            state       <= RESP;
            o_rsp_valid <= 1'b1;
            o_rsp_err   <= 1'b0;
            o_rsp_rdata <= fmt_rd(i_rdata, size_q, addr_lo_q);
          end
        end
        RD_C: begin
          state       <= RESP;
          o_rsp_valid <= 1'b1;
          o_rsp_err   <= 1'b0;
          o_rsp_rdata <= {i_rdata, lo_q};
        end
        RESP: begin
          if (i_rsp_ready) begin
            state       <= IDLE;
            o_rsp_valid <= 1'b0;
            o_rsp_err   <= 1'b0;
            o_rsp_rdata <= 64'h0;
            o_req_ready <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          o_req_ready <= 1'b1;
          o_rsp_valid <= 1'b0;
          o_we        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clint_bridge.sv
// tb_clint_bridge: directed vector bench for clint_bridge with a simple
// CLINT register-file model behind the offset/we/wdata/rdata port.
module tb_clint_bridge;

  localparam logic [31:0] BASE = 32'h6000_0000;

  logic        CLK;
  logic        RST_X;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [31:0] i_req_addr;
  logic        i_req_we;
  logic [1:0]  i_req_size;
  logic [63:0] i_req_wdata;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [63:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic [15:0] o_offset;
  logic        o_we;
  logic [31:0] o_wdata;
  logic [31:0] i_rdata;

  clint_bridge dut (
    .CLK(CLK), .RST_X(RST_X),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_addr(i_req_addr), .i_req_we(i_req_we), .i_req_size(i_req_size),
    .i_req_wdata(i_req_wdata),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
    .o_offset(o_offset), .o_we(o_we), .o_wdata(o_wdata), .i_rdata(i_rdata)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // CLINT model: registered read of the offset held last cycle, write on o_we.
  logic [31:0] mem [0:16383];
  logic        mem_clr;
  always @(posedge CLK) begin
    if (mem_clr) begin
      for (int i = 0; i < 16384; i++) mem[i] <= 32'h0;
      mem[16'hBFF8 >> 2] <= 32'hDEAD_0007;
    end else begin
      i_rdata <= mem[o_offset[15:2]];
      if (o_we) mem[o_offset[15:2]] <= o_wdata;
    end
  end

  // Log of CLINT write beats.
  int          beat_cnt = 0;
  logic [15:0] beat_off [0:63];
  logic [31:0] beat_dat [0:63];
  always @(posedge CLK) begin
    if (o_we && !mem_clr) begin
      beat_off[beat_cnt[5:0]] <= o_offset;
      beat_dat[beat_cnt[5:0]] <= o_wdata;
      beat_cnt <= beat_cnt + 1;
    end
  end

  int nchk = 0;
  int nerr = 0;
  logic [15:0] exp_off = 16'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [1:0]  size;
    logic [63:0] wdata;
    logic        err;
    logic [63:0] rdata;
    int          lat;
    int          beats;
  } vec_t;

  vec_t tbl [20];

  task automatic issue(input logic [31:0] addr, input logic we, input logic [1:0] size,
                       input logic [63:0] wdata);
    @(negedge CLK);
    i_req_addr  = addr;
    i_req_we    = we;
    i_req_size  = size;
    i_req_wdata = wdata;
    i_req_valid = 1'b1;
    @(posedge CLK);
    #1 i_req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (o_rsp_valid) break;
      lat++;
    end
  endtask

  task automatic run_req(input string nm, input vec_t v);
    int          lat;
    int          b0;
    logic [31:0] o;
    b0 = beat_cnt;
    o  = v.addr - BASE;
    if (!v.err) exp_off = {o[15:2], 2'b00} + ((v.size == 2'd3) ? 16'd4 : 16'd0);
    @(negedge CLK);
    chk({nm, " req_ready"}, {63'h0, o_req_ready}, 64'h1);
    issue(v.addr, v.we, v.size, v.wdata);
    wait_rsp(lat);
    chk({nm, " latency"}, 64'(lat), 64'(v.lat));
    chk({nm, " err"}, {63'h0, o_rsp_err}, {63'h0, v.err});
    chk({nm, " rdata"}, o_rsp_rdata, v.rdata);
    chk({nm, " beats"}, 64'(beat_cnt - b0), 64'(v.beats));
    chk({nm, " offset"}, {48'h0, o_offset}, {48'h0, exp_off});
    if (v.beats >= 1) begin
      chk({nm, " beat0 off"}, {48'h0, beat_off[b0[5:0]]}, {48'h0, o[15:2], 2'b00});
      chk({nm, " beat0 dat"}, {32'h0, beat_dat[b0[5:0]]}, {32'h0, v.wdata[31:0]});
    end
    if (v.beats >= 2) begin
      chk({nm, " beat1 off"}, {48'h0, beat_off[6'(b0 + 1)]}, {48'h0, o[15:0] + 16'd4});
      chk({nm, " beat1 dat"}, {32'h0, beat_dat[6'(b0 + 1)]}, {32'h0, v.wdata[63:32]});
    end
    i_rsp_ready = 1'b1;
    @(posedge CLK);
    #1 i_rsp_ready = 1'b0;
    @(negedge CLK);
    chk({nm, " rsp dropped"}, {63'h0, o_rsp_valid}, 64'h0);
    chk({nm, " ready back"}, {63'h0, o_req_ready}, 64'h1);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, " req_ready"}, {63'h0, o_req_ready}, 64'h1);
    chk({nm, " rsp_valid"}, {63'h0, o_rsp_valid}, 64'h0);
    chk({nm, " rsp_err"}, {63'h0, o_rsp_err}, 64'h0);
    chk({nm, " rsp_rdata"}, o_rsp_rdata, 64'h0);
    chk({nm, " offset"}, {48'h0, o_offset}, 64'h0);
    chk({nm, " we"}, {63'h0, o_we}, 64'h0);
    chk({nm, " wdata"}, {32'h0, o_wdata}, 64'h0);
  endtask

  initial begin
    int   lat;
    vec_t v;
    //         addr           we    size  wdata                   err   rdata                   lat beats
    tbl[0]  = '{32'h6000_BFF8, 1'b0, 2'd3, 64'h0,                  1'b0, 64'h0000_0000_DEAD_0007, 3, 0};
    tbl[1]  = '{32'h6000_4000, 1'b1, 2'd2, 64'h0000_0000_1234_5678, 1'b0, 64'h0,                  1, 1};
    tbl[2]  = '{32'h6000_4000, 1'b0, 2'd2, 64'h0,                  1'b0, 64'h0000_0000_1234_5678, 2, 0};
    tbl[3]  = '{32'h6000_4002, 1'b0, 2'd1, 64'h0,                  1'b0, 64'h0000_0000_0000_1234, 2, 0};
    tbl[4]  = '{32'h6000_4003, 1'b0, 2'd0, 64'h0,                  1'b0, 64'h0000_0000_0000_0012, 2, 0};
    tbl[5]  = '{32'h6000_4001, 1'b0, 2'd0, 64'h0,                  1'b0, 64'h0000_0000_0000_0056, 2, 0};
    tbl[6]  = '{32'h6000_0000, 1'b1, 2'd2, 64'h0000_0000_0000_0001, 1'b0, 64'h0,                  1, 1};
    tbl[7]  = '{32'h6000_0001, 1'b0, 2'd0, 64'h0,                  1'b0, 64'h0,                  2, 0};
    tbl[8]  = '{32'h6000_0000, 1'b0, 2'd0, 64'h0,                  1'b0, 64'h0000_0000_0000_0001, 2, 0};
    tbl[9]  = '{32'h6000_4000, 1'b1, 2'd3, 64'h0000_0001_0000_0002, 1'b0, 64'h0,                  2, 2};
    tbl[10] = '{32'h6000_4000, 1'b0, 2'd3, 64'h0,                  1'b0, 64'h0000_0001_0000_0002, 3, 0};
    tbl[11] = '{32'h6001_0000, 1'b0, 2'd2, 64'h0,                  1'b1, 64'h0,                  0, 0};
    tbl[12] = '{32'h5FFF_FFFC, 1'b0, 2'd2, 64'h0,                  1'b1, 64'h0,                  0, 0};
    tbl[13] = '{32'h6000_0002, 1'b1, 2'd2, 64'h0000_0000_AAAA_AAAA, 1'b1, 64'h0,                  0, 0};
    tbl[14] = '{32'h6000_0000, 1'b1, 2'd1, 64'h0000_0000_0000_BBBB, 1'b1, 64'h0,                  0, 0};
    tbl[15] = '{32'h6000_4000, 1'b1, 2'd0, 64'h0000_0000_0000_00CC, 1'b1, 64'h0,                  0, 0};
    tbl[16] = '{32'h6000_4004, 1'b0, 2'd3, 64'h0,                  1'b1, 64'h0,                  0, 0};
    tbl[17] = '{32'h6000_4001, 1'b0, 2'd1, 64'h0,                  1'b1, 64'h0,                  0, 0};
    tbl[18] = '{32'h6000_FFFC, 1'b0, 2'd2, 64'h0,                  1'b0, 64'h0,                  2, 0};
    tbl[19] = '{32'h6000_FFF8, 1'b0, 2'd3, 64'h0,                  1'b0, 64'h0,                  3, 0};

    RST_X = 1'b0; mem_clr = 1'b1;
    i_req_valid = 1'b1; i_req_addr = 32'h6000_4000; i_req_we = 1'b1;
    i_req_size = 2'd2; i_req_wdata = 64'h0; i_rsp_ready = 1'b0;
    repeat (3) @(negedge CLK);
    chk_reset_vals("reset");
    i_req_valid = 1'b0;
    mem_clr = 1'b0;
    @(negedge CLK);
    RST_X = 1'b1;

    for (int i = 0; i < 20; i++) run_req($sformatf("vec%0d", i), tbl[i]);

    // Response back-pressure: held stable, no new request accepted.
    issue(32'h6000_4000, 1'b0, 2'd2, 64'h0);
    wait_rsp(lat);
    chk("hold latency", 64'(lat), 64'd2);
    i_req_valid = 1'b1; i_req_addr = 32'h6000_0000; i_req_we = 1'b1; i_req_size = 2'd2;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("hold%0d valid", k), {63'h0, o_rsp_valid}, 64'h1);
      chk($sformatf("hold%0d rdata", k), o_rsp_rdata, 64'h0000_0000_0000_0002);
      chk($sformatf("hold%0d req_ready", k), {63'h0, o_req_ready}, 64'h0);
      @(negedge CLK);
    end
    i_req_valid = 1'b0;
    i_rsp_ready = 1'b1;
    @(posedge CLK);
    #1 i_rsp_ready = 1'b0;
    @(negedge CLK);
    chk("hold release ready", {63'h0, o_req_ready}, 64'h1);
    chk("hold release valid", {63'h0, o_rsp_valid}, 64'h0);
    chk("hold no side write", {32'h0, mem[0]}, 64'h1);

    // Reset during the high write beat of a dword write.
    issue(32'h6000_8000, 1'b1, 2'd3, 64'hAAAA_AAAA_5555_5555);
    @(negedge CLK);
    @(negedge CLK);
    chk("wr_hi we", {63'h0, o_we}, 64'h1);
    chk("wr_hi offset", {48'h0, o_offset}, 64'h8004);
    RST_X = 1'b0;
    #1;
    chk_reset_vals("midreset");
    @(negedge CLK);
    RST_X = 1'b1;
    exp_off = 16'h0;
    v = '{32'h6000_8000, 1'b0, 2'd3, 64'h0, 1'b0, 64'h0000_0000_5555_5555, 3, 0};
    run_req("after reset", v);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/clint_bridge.md
# clint_bridge

Bus-side front end of the core-local interruptor. Accepts single memory requests from the CPU data port via a valid/ready handshake. Decodes and checks the address against the CLINT window and sequences one or two 32-bit register accesses onto the CLINT offset/we/wdata/rdata port. Returns a 64-bit read result or an error flag on a valid/ready response channel.

## Interface
- BASE_ADDR, 32'h6000_0000, byte address of the CLINT window
- WIN_SIZE, 32'h0001_0000, window size in bytes; offset = addr - BASE_ADDR, driven as 16 bits
- CLK  in  1  clock
- RST_X  in  1  reset; asynchronous, active-low
- i_req_valid  in  1  request valid
- o_req_ready  out  1  request accepted when high with i_req_valid
- i_req_addr  in  32  byte address
- i_req_we  in  1  1 = write
- i_req_size  in  2  0 byte, 1 half, 2 word, 3 dword
- i_req_wdata  in  64  write data; [31:0] for word, full for dword
- o_rsp_valid  out  1  response valid
- i_rsp_ready  in  1  response consumed
- o_rsp_rdata  out  64  read data, zero for writes and errors
- o_rsp_err  out  1  access rejected, no CLINT side effect
- o_offset  out  16  CLINT register offset
- o_we  out  1  CLINT write strobe, one cycle per beat
- o_wdata  out  32  CLINT write data
- i_rdata  in  32  CLINT read data; reflects the o_offset held in the previous cycle

## Operation
- FSM states: IDLE, WR_LO, WR_HI, RD_A, RD_B, RD_C, RESP.
- IDLE: o_req_ready=1. On handshake, latch addr/size/we/wdata and compute off = addr - BASE_ADDR.
- Error check at accept; any failure goes to RESP with err=1:
  - out of window: addr < BASE_ADDR or off >= WIN_SIZE
  - misaligned: half needs addr[0]=0, word needs addr[1:0]=0, dword needs addr[2:0]=0
  - any byte or half write
- Write, word: WR_LO, then RESP.
- Write, dword: WR_LO, then WR_HI, then RESP.
  - WR_LO drives o_offset=off&~3, o_we=1, o_wdata=wdata[31:0].
  - WR_HI drives o_offset=off+4, o_we=1, o_wdata=wdata[63:32].
- Read, all sizes: RD_A drives o_offset=off&~3, o_we=0.
- RD_B captures i_rdata into lo.
  - dword: RD_B also drives o_offset=off+4 and goes to RD_C; RD_C captures i_rdata into hi.
  - otherwise: RD_B goes to RESP.
- Sub-word read: o_rsp_rdata = lo >> (8*addr[1:0]), masked to 8 or 16 bits, zero-extended.
- Word read: {32'h0, lo}. Dword read: {hi, lo}.
- RESP: o_rsp_valid=1 with rdata/err stable. Leave RESP only on i_rsp_ready, then go to IDLE.
- o_req_ready is low in every state except IDLE, so there is one outstanding request at most.
- o_offset holds its last value outside access states. o_we=0 outside WR_LO/WR_HI.
- Dword reads and writes are two non-atomic beats, low word first. Consequences are accepted, not corrected:
  - An mtime read can tear on a carry out of bit 31.
  - A mtimecmp write passes through an intermediate value for one cycle.
  - Software uses hi-lo-hi reads and writes the high word to all ones first.

## Timing
- Request handshake at edge E0.
- Response valid from the cycle after the edge below, and held until i_rsp_ready:
  - error: E0
  - word write: E1
  - dword write: E2
  - byte/half/word read: E2
  - dword read: E3
- RESP to IDLE takes one cycle. Minimum spacing between accepted requests is latency + 1 cycles.
- Reset (async, any state) forces:
  - state IDLE, o_req_ready=1
  - o_rsp_valid=0, o_rsp_err=0, o_rsp_rdata=0
  - o_offset=0, o_we=0, o_wdata=0
- Reset mid-dword-write leaves the CLINT with only the low word written. An in-flight response is dropped.
- Response with i_rsp_ready held low: stay in RESP indefinitely. i_req_valid is ignored and not accepted.
- Simultaneous i_req_valid and RST_X low: the request is not accepted.

## Test plan
- Word write 0x6000_4000 = 0x1234_5678 -> one o_we pulse, offset 0x4000, wdata 0x1234_5678; rsp valid at E1, err=0, rdata=0.
- Dword read 0x6000_BFF8 after reset -> offsets 0xBFF8 then 0xBFFC on consecutive cycles; rsp at E3 with rdata[63:32]=0 and rdata[31:0] equal to the mtime count sampled.
- Dword write 0x6000_4000 = 0x0000_0001_0000_0002 -> beats (0x4000, 0x2) then (0x4004, 0x1); rsp at E2.
- Byte read 0x6000_0001 with msip0=1 -> rdata=0; byte read 0x6000_0000 -> rdata=1.
- Error cases, each with err=1 at E0, no o_we pulse, and no offset change:
  - addr 0x6001_0000
  - addr 0x5FFF_FFFC
  - word at 0x6000_0002
  - half write
- Hold i_rsp_ready=0 for 5 cycles -> rsp stable and req_ready=0 throughout. Assert RST_X low in WR_HI of a dword write -> all outputs return to reset values immediately.
